// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Imported by the arbiter and the scheduler top.
package uart_sched_pkg;

    localparam int N_REQ_DEF   = 2;
    localparam int DATA_W_DEF  = 8;
    localparam int MAX_PKT_DEF = 16;

    localparam int ID_W  = $clog2(N_REQ_DEF);
    localparam int CNT_W = $clog2(MAX_PKT_DEF);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Width of a counter able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping.
// Purely combinational; gnt is one-hot or zero.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + 1 + i) % N;
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ byte streams with
// round-robin arbitration and packet locking.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_PKT = MAX_PKT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      locked
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(MAX_PKT);

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     grant_q;
    logic              locked_q;
    logic [DATA_W-1:0] tx_data_q;

    logic [N_REQ-1:0]  own_mask;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              accept;
    logic              pkt_end;
    logic [DATA_W-1:0] win_data;

    // While a packet is open only its owner may be picked
    assign own_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
    assign eligible = locked_q ? (req_valid & own_mask) : req_valid;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign accept   = (state_q == IDLE) && pick_any;
    assign win_data = req_data[pick_idx*DATA_W +: DATA_W];
    assign pkt_end  = req_last[pick_idx] ||
                      (cnt_q == CW'(MAX_PKT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept)   state_d = START;
            START:                   state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock, count and pointer only move on an accepted byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            ptr_q     <= IW'(N_REQ - 1);
            grant_q   <= '0;
            locked_q  <= 1'b0;
            tx_data_q <= '0;
        end else if (accept) begin
            tx_data_q <= win_data;
            grant_q   <= pick_idx;
            if (pkt_end) begin
                locked_q <= 1'b0;
                cnt_q    <= '0;
                ptr_q    <= pick_idx;
            end else begin
                locked_q <= 1'b1;
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

    assign req_ready = accept ? pick_gnt : '0;
    assign tx_start  = (state_q == START);
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_q;
    assign locked    = locked_q;

endmodule
